// File: rtl/ibex_msg_mailbox.sv
// Inter-core message mailbox: a staging buffer feeds a TX FIFO onto the link, and an
// address filter feeds an RX FIFO that the core reads.

module ibex_msg_mailbox_fifo #(
    parameter int Width = 8,
    parameter int Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             valid_o,
    output logic [Width-1:0] rdata_o
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign valid_o = (cnt_q != '0);
    // Gate with valid so stale storage never shows after reset
    assign rdata_o = valid_o ? mem_q[rptr_q] : '0;

    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && valid_o;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        if (do_push) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end
endmodule

module ibex_msg_mailbox #(
    parameter int DataWidth = 32,
    parameter int MaxWords  = 4,
    parameter int AddrWidth = 5,
    parameter int TxDepth   = 2,
    parameter int RxDepth   = 2,
    localparam int LenW     = (MaxWords > 1) ? $clog2(MaxWords) : 1,
    localparam int MsgW     = MaxWords * DataWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] node_id_i,
    input  logic                 stg_we_i,
    input  logic [LenW-1:0]      stg_idx_i,
    input  logic [DataWidth-1:0] stg_wdata_i,
    input  logic                 send_i,
    input  logic [LenW-1:0]      send_len_i,
    input  logic [AddrWidth-1:0] send_addr_i,
    output logic                 tx_full_o,
    output logic [MsgW-1:0]      tx_data_o,
    output logic [LenW-1:0]      tx_len_o,
    output logic [AddrWidth-1:0] tx_addr_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    input  logic                 rx_valid_i,
    output logic                 rx_ready_o,
    input  logic [AddrWidth-1:0] rx_addr_i,
    input  logic [LenW-1:0]      rx_len_i,
    input  logic [MsgW-1:0]      rx_data_i,
    output logic                 rd_valid_o,
    output logic [AddrWidth-1:0] rd_addr_o,
    output logic [LenW-1:0]      rd_len_o,
    output logic [MsgW-1:0]      rd_data_o,
    input  logic                 rd_pop_i,
    output logic                 err_send_o,
    output logic [15:0]          drop_cnt_o
);
    localparam int EntW = AddrWidth + LenW + MsgW;

    logic [MsgW-1:0] stg_q, stg_d;
    logic            err_q, err_d;
    logic [15:0]     drop_q, drop_d;
    logic            rx_full, rx_hs, rx_match;
    logic [EntW-1:0] tx_wdata, tx_rdata, rx_wdata, rx_rdata;

    function automatic logic [MsgW-1:0] mask_words(input logic [MsgW-1:0] d,
                                                   input logic [LenW-1:0] len);
        for (int k = 0; k < MaxWords; k++) begin
            if (k > int'(len)) d[k*DataWidth +: DataWidth] = '0;
        end
        return d;
    endfunction

    always_comb begin
        stg_d = stg_q;
        for (int k = 0; k < MaxWords; k++) begin
            if (stg_we_i && int'(stg_idx_i) == k) begin
                stg_d[k*DataWidth +: DataWidth] = stg_wdata_i;
            end
        end
    end

    // Commit from stg_d so a same-cycle staging write is included
    assign tx_wdata = {send_addr_i, send_len_i, mask_words(stg_d, send_len_i)};

    assign rx_ready_o = !rx_full;
    assign rx_hs      = rx_valid_i && rx_ready_o;
    assign rx_match   = (rx_addr_i == node_id_i) || (&rx_addr_i);
    assign rx_wdata   = {rx_addr_i, rx_len_i, mask_words(rx_data_i, rx_len_i)};

    always_comb begin
        err_d  = err_q || (send_i && tx_full_o);
        drop_d = drop_q;
        if (rx_hs && !rx_match && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stg_q  <= '0;
            err_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            stg_q  <= stg_d;
            err_q  <= err_d;
            drop_q <= drop_d;
        end
    end

    ibex_msg_mailbox_fifo #(.Width(EntW), .Depth(TxDepth)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (send_i),
        .wdata_i (tx_wdata),
        .pop_i   (tx_ready_i),
        .full_o  (tx_full_o),
        .valid_o (tx_valid_o),
        .rdata_o (tx_rdata)
    );

    ibex_msg_mailbox_fifo #(.Width(EntW), .Depth(RxDepth)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rx_hs && rx_match),
        .wdata_i (rx_wdata),
        .pop_i   (rd_pop_i),
        .full_o  (rx_full),
        .valid_o (rd_valid_o),
        .rdata_o (rx_rdata)
    );

    assign {tx_addr_o, tx_len_o, tx_data_o} = tx_rdata;
    assign {rd_addr_o, rd_len_o, rd_data_o} = rx_rdata;
    assign err_send_o = err_q;
    assign drop_cnt_o = drop_q;
endmodule
